// File: rtl/ex_hazard_ctrl_if.sv
// Signal bundle between the EX-stage hazard controller and the pipeline around it.
// The slave side is the controller; the master side drives decode/pipeline status.
interface ex_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic [3:0]       id_srcA;
  logic [3:0]       id_srcB;
  logic             id_useA;
  logic             id_useB;
  logic             id_branch_flags;
  logic             id_branch_taken;
  logic             id_halt;
  logic [3:0]       ex_srcA;
  logic [3:0]       ex_srcB;
  logic [3:0]       ex_regW;
  logic             ex_regWrite;
  logic             ex_memRead;
  logic             ex_setsFlags;
  logic [3:0]       mem_regW;
  logic             mem_regWrite;
  logic [3:0]       wb_regW;
  logic             wb_regWrite;
  logic             mem_busy;
  logic             stall_pc;
  logic             stall_ifid;
  logic             flush_ifid;
  logic             bubble_idex;
  logic             freeze_back;
  logic [1:0]       fwdA;
  logic [1:0]       fwdB;
  logic             halted;
  logic [CNT_W-1:0] bubble_cnt;

  modport slave (
    input  id_srcA, id_srcB, id_useA, id_useB, id_branch_flags, id_branch_taken,
           id_halt, ex_srcA, ex_srcB, ex_regW, ex_regWrite, ex_memRead,
           ex_setsFlags, mem_regW, mem_regWrite, wb_regW, wb_regWrite, mem_busy,
    output stall_pc, stall_ifid, flush_ifid, bubble_idex, freeze_back,
           fwdA, fwdB, halted, bubble_cnt
  );

  modport master (
    output id_srcA, id_srcB, id_useA, id_useB, id_branch_flags, id_branch_taken,
           id_halt, ex_srcA, ex_srcB, ex_regW, ex_regWrite, ex_memRead,
           ex_setsFlags, mem_regW, mem_regWrite, wb_regW, wb_regWrite, mem_busy,
    input  stall_pc, stall_ifid, flush_ifid, bubble_idex, freeze_back,
           fwdA, fwdB, halted, bubble_cnt
  );
endinterface

// File: rtl/ex_hazard_ctrl.sv
// EX-stage pipeline sequencer: operand forwarding select, load-use/flag-use bubbles,
// branch flush, memory-busy freeze and HLT drain.
module ex_hazard_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned CNT_W        = 16
) (
  input logic               clk,
  input logic               rst_n,
  ex_hazard_ctrl_if.slave   bus
);
  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_e;

  state_e           state_q, state_d;
  logic [1:0]       dcnt_q, dcnt_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  logic load_use, flag_use, hazard;
  logic stall_pc, stall_ifid, flush_ifid, bubble_idex, freeze_back;
  logic [1:0] fwd_a, fwd_b;

  always_comb begin
    load_use = bus.ex_memRead && bus.ex_regWrite && (bus.ex_regW != 4'd0) &&
               ((bus.id_useA && (bus.id_srcA == bus.ex_regW)) ||
                (bus.id_useB && (bus.id_srcB == bus.ex_regW)));
    flag_use = bus.id_branch_flags && bus.ex_setsFlags;
    hazard   = load_use || flag_use;
  end

  // EX/MEM result is newer than MEM/WB, so it takes precedence; R0 is hardwired zero.
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (bus.mem_regWrite && (bus.mem_regW != 4'd0) && (bus.mem_regW == bus.ex_srcA))
      fwd_a = 2'b10;
    else if (bus.wb_regWrite && (bus.wb_regW != 4'd0) && (bus.wb_regW == bus.ex_srcA))
      fwd_a = 2'b01;
    if (bus.mem_regWrite && (bus.mem_regW != 4'd0) && (bus.mem_regW == bus.ex_srcB))
      fwd_b = 2'b10;
    else if (bus.wb_regWrite && (bus.wb_regW != 4'd0) && (bus.wb_regW == bus.ex_srcB))
      fwd_b = 2'b01;
  end

  always_comb begin
    state_d      = state_q;
    dcnt_d       = dcnt_q;
    stall_pc     = 1'b0;
    stall_ifid   = 1'b0;
    flush_ifid   = 1'b0;
    bubble_idex  = 1'b0;
    freeze_back  = 1'b0;
    if (bus.mem_busy) begin
      stall_pc    = 1'b1;
      stall_ifid  = 1'b1;
      freeze_back = 1'b1;
    end else begin
      unique case (state_q)
        HALTED: begin
          stall_pc    = 1'b1;
          stall_ifid  = 1'b1;
          freeze_back = 1'b1;
        end
        DRAIN: begin
          stall_pc   = 1'b1;
          flush_ifid = 1'b1;
          dcnt_d     = dcnt_q + 2'd1;
          if (dcnt_q == 2'(DRAIN_CYCLES - 1)) state_d = HALTED;
        end
        default: begin
          if (hazard) begin
            stall_pc    = 1'b1;
            stall_ifid  = 1'b1;
            bubble_idex = 1'b1;
          end else if (bus.id_halt) begin
            stall_pc   = 1'b1;
            flush_ifid = 1'b1;
            state_d    = DRAIN;
            dcnt_d     = 2'd0;
          end else if (bus.id_branch_taken) begin
            flush_ifid = 1'b1;
          end
        end
      endcase
    end
  end

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (bubble_idex && !bus.mem_busy && !(&bubble_cnt_q))
      bubble_cnt_d = bubble_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= RUN;
      dcnt_q       <= '0;
      bubble_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      dcnt_q       <= dcnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign bus.stall_pc    = stall_pc;
  assign bus.stall_ifid  = stall_ifid;
  assign bus.flush_ifid  = flush_ifid;
  assign bus.bubble_idex = bubble_idex;
  assign bus.freeze_back = freeze_back;
  assign bus.fwdA        = fwd_a;
  assign bus.fwdB        = fwd_b;
  assign bus.halted      = (state_q == HALTED);
  assign bus.bubble_cnt  = bubble_cnt_q;
endmodule

// File: doc/ex_hazard_ctrl.md
Name: ex_hazard_ctrl

Overview:
- Pipeline sequencing controller for the EX-stage ALU datapath.
- Selects ALU operand forwarding sources and detects load-use and flag-use hazards, inserting one-cycle bubbles.
- Flushes IF/ID on taken branches, freezes the whole pipe while memory is busy, and drains the pipeline on HLT.
- Sits beside the ID/EX/MEM/WB pipeline registers; its outputs drive their enables, the PC enable and the ALU input muxes.

Parameters:
- DRAIN_CYCLES, 3, unfrozen cycles after HLT leaves ID before `halted` asserts.
- CNT_W, 16, width of the saturating bubble counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset: synchronous, active-low.
- id_srcA, id_srcB  in  4 each  source registers of the instruction in ID.
- id_useA, id_useB  in  1 each  ID instruction reads srcA/srcB.
- id_branch_flags  in  1  ID holds a conditional branch reading Z/V/N.
- id_branch_taken  in  1  ID branch resolved taken.
- id_halt  in  1  ID holds HLT.
- ex_srcA, ex_srcB  in  4 each  source registers of the instruction in EX.
- ex_regW  in  4  destination register of the instruction in EX.
- ex_regWrite, ex_memRead, ex_setsFlags  in  1 each  control bits of the instruction in EX.
- mem_regW  in  4  destination register in MEM.
- mem_regWrite  in  1  MEM write-enable.
- wb_regW  in  4  destination register in WB.
- wb_regWrite  in  1  WB write-enable.
- mem_busy  in  1  memory system is stalling.
- stall_pc  out  1  hold PC.
- stall_ifid  out  1  hold IF/ID.
- flush_ifid  out  1  zero IF/ID to a NOP.
- bubble_idex  out  1  load a NOP into ID/EX.
- freeze_back  out  1  hold ID/EX, EX/MEM and MEM/WB.
- fwdA, fwdB  out  2 each  ALU input source: 00 register file, 10 EX/MEM, 01 MEM/WB.
- halted  out  1  pipeline drained after HLT.
- bubble_cnt  out  CNT_W  count of inserted bubbles.

Behaviour:
- State machine: RUN, DRAIN, HALTED. Drain counter `dcnt` is 2 bits. `bubble_cnt` is a register.
- On any rising edge with rst_n=0:
  - state becomes RUN, dcnt becomes 0, bubble_cnt becomes 0.
  - All outputs go to 0 (combinational outputs evaluate with state=RUN).
  - Reset mid-drain or while HALTED returns to RUN.
- Output computation, in priority order; all outputs are combinational from inputs and state:
  1. mem_busy=1: stall_pc=stall_ifid=freeze_back=1; flush_ifid=bubble_idex=0. State, dcnt and bubble_cnt hold.
  2. HALTED: stall_pc=stall_ifid=freeze_back=1; state holds until reset.
  3. DRAIN: stall_pc=1, flush_ifid=1. dcnt increments each cycle; at dcnt==DRAIN_CYCLES-1, next state is HALTED.
  4. RUN, hazard: stall_pc=stall_ifid=bubble_idex=1. A hazard is either:
     - load-use: ex_memRead & ex_regWrite & ex_regW!=0 & ((id_useA & id_srcA==ex_regW) | (id_useB & id_srcB==ex_regW));
     - flag-use: id_branch_flags & ex_setsFlags.
     
     id_branch_taken and id_halt are ignored in a hazard cycle.
  5. RUN, id_halt: stall_pc=1, flush_ifid=1; next state DRAIN, dcnt=0.
  6. RUN, id_branch_taken: flush_ifid=1 only.
- bubble_cnt increments by 1 exactly when bubble_idex=1 and mem_busy=0; it saturates at all ones.
- Forwarding for A (B identical using ex_srcB):
  - fwdA=10 if mem_regWrite & mem_regW!=0 & mem_regW==ex_srcA;
  - else 01 if wb_regWrite & wb_regW!=0 & wb_regW==ex_srcA;
  - else 00.
  - EX/MEM wins over MEM/WB. R0 is never forwarded.
  - Forwarding is evaluated in every state, including during mem_busy.
- halted = (state==HALTED).
- Latency: hazard outputs are same-cycle. A bubble lasts exactly one unfrozen cycle; the next cycle the load sits in MEM and is forwarded via fwd=10.

Test Plan:
- Load-use bubble: EX LLB-load with ex_memRead=1, ex_regW=3; ID ADD with srcA=3, useA=1 -> stall_pc=stall_ifid=bubble_idex=1 for one cycle, bubble_cnt goes 0->1. Next cycle, mem_regW=3 with ex_srcA=3 -> fwdA=10.
- Double forward: mem_regW=5 and wb_regW=5, both regWrite=1, ex_srcB=5 -> fwdB=10. Same with mem_regW=0 -> fwdB=01. wb_regW=0 -> fwdB=00.
- Flag hazard then taken branch: ex_setsFlags=1 with id_branch_flags=1 and id_branch_taken=1 -> bubble, flush_ifid=0. Next cycle with ex_setsFlags=0 -> flush_ifid=1, no bubble.
- mem_busy priority: mem_busy=1 concurrent with a load-use hazard for 4 cycles -> freeze_back=1, bubble_idex=0, bubble_cnt unchanged. After release, exactly one bubble.
- Halt drain: id_halt=1 in RUN -> 3 unfrozen cycles of stall_pc=flush_ifid=1, then halted=1 persists. Assert mem_busy for 2 cycles mid-drain -> halted asserts 2 cycles later.
- Reset: rst_n=0 for one edge while HALTED with bubble_cnt=7 -> halted=0, bubble_cnt=0, all stall/flush outputs 0 with idle inputs.
